// File: rtl/wait_state_ram.sv
// Byte-addressed big-endian RAM with MFA/MOC handshake, programmable wait states, byte/half/word access.
// Latency: MOC rises WAIT_STATES+1 clock edges after the edge that accepts MFA.
// Backpressure: one op in flight; MOC/Busy hold until MFA drops, and MFA must be low for an edge before the next request.
//
// Ports: Clk/Clear (sync active-low reset), MFA/RW/DataSize/Signed/Addr/DataIn request side,
//        DataOut/MOC/Busy/AlignErr completion side. Mem[] is left unreset so it can be preloaded.
module wait_state_ram #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_STATES = 2
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        DataSize,
    input  logic              Signed,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Busy,
    output logic              AlignErr
);

    localparam int EW = ADDR_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic              sgn_q;
    logic [1:0]        size_q;
    logic [31:0]       din_q;

    logic [7:0]        Mem [0:DEPTH-1];

    logic              accept;
    logic              commit;
    logic              release_op;
    logic [1:0]        last_off;
    logic [EW-1:0]     last_idx;
    logic              err;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rdata;

    assign accept     = (state == ST_IDLE) && MFA;
    // The op commits on the edge that enters DONE, i.e. one edge after the counter has hit zero.
    assign commit     = (state == ST_WAIT) && (cnt == 4'd0);
    assign release_op = (state == ST_DONE) && !MFA;

    assign a0 = addr_q;
    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    // Error check on the captured request; the range test uses widened arithmetic so
    // an access that runs off the top of the array never aliases back to low addresses.
    always_comb begin
        last_off = 2'd0;
        err      = 1'b0;
        case (size_q)
            2'b00: last_off = 2'd0;
            2'b01: begin
                last_off = 2'd1;
                err      = addr_q[0];
            end
            2'b10: begin
                last_off = 2'd3;
                err      = |addr_q[1:0];
            end
            default: begin
                last_off = 2'd3;
                err      = 1'b1;
            end
        endcase
        last_idx = {2'b00, addr_q} + EW'(last_off);
        if (last_idx >= EW'(DEPTH)) begin
            err = 1'b1;
        end
    end

    // Big-endian read assembly with optional sign extension.
    always_comb begin
        rdata = 32'd0;
        case (size_q)
            2'b00:   rdata = sgn_q ? {{24{Mem[a0][7]}}, Mem[a0]} : {24'd0, Mem[a0]};
            2'b01:   rdata = sgn_q ? {{16{Mem[a0][7]}}, Mem[a0], Mem[a1]}
                               : {16'd0, Mem[a0], Mem[a1]};
            default: rdata = {Mem[a0], Mem[a1], Mem[a2], Mem[a3]};
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (MFA)               state_nxt = ST_WAIT;
            ST_WAIT: if (cnt == 4'd0)       state_nxt = ST_DONE;
            ST_DONE: if (!MFA)              state_nxt = ST_IDLE;
            default:                        state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clear) begin
            cnt      <= 4'd0;
            MOC      <= 1'b0;
            Busy     <= 1'b0;
            AlignErr <= 1'b0;
            DataOut  <= 32'd0;
        end else begin
            if (accept) begin
                cnt  <= 4'(WAIT_STATES);
                Busy <= 1'b1;
            end
            if ((state == ST_WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                MOC      <= 1'b1;
                AlignErr <= err;
                if (!err && rw_q) begin
                    DataOut <= rdata;
                end
            end
            if (release_op) begin
                MOC      <= 1'b0;
                Busy     <= 1'b0;
                AlignErr <= 1'b0;
            end
        end
    end

    // Request fields are only meaningful while Busy, so they need no reset.
    always_ff @(posedge Clk) begin
        if (accept) begin
            addr_q <= Addr;
            rw_q   <= RW;
            size_q <= DataSize;
            sgn_q  <= Signed;
            din_q  <= DataIn;
        end
    end

    // Gating on Clear drops a write whose commit edge coincides with reset.
    always_ff @(posedge Clk) begin
        if (Clear && commit && !err && !rw_q) begin
            case (size_q)
                2'b00: Mem[a0] <= din_q[7:0];
                2'b01: begin
                    Mem[a0] <= din_q[15:8];
                    Mem[a1] <= din_q[7:0];
                end
                default: begin
                    Mem[a0] <= din_q[31:24];
                    Mem[a1] <= din_q[23:16];
                    Mem[a2] <= din_q[15:8];
                    Mem[a3] <= din_q[7:0];
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_ram.sv
// Directed bench for wait_state_ram: one instance with 2 wait states, one with none.
// Latency: checks MOC arrival edge count per op.
// Backpressure: holds MFA after MOC and checks the op is not repeated.
module tb_wait_state_ram;

    logic        Clk = 1'b0;
    logic        Clear;
    logic        MFA;
    logic        MFA0;
    logic        RW;
    logic [1:0]  DataSize;
    logic        Signed;
    logic [8:0]  Addr;
    logic [31:0] DataIn;
    logic [31:0] dout, dout0;
    logic        moc, moc0, busy, busy0, aerr, aerr0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    wait_state_ram #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(2)) dut (
        .Clk(Clk), .Clear(Clear), .MFA(MFA), .RW(RW), .DataSize(DataSize),
        .Signed(Signed), .Addr(Addr), .DataIn(DataIn),
        .DataOut(dout), .MOC(moc), .Busy(busy), .AlignErr(aerr)
    );

    wait_state_ram #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Clear(Clear), .MFA(MFA0), .RW(RW), .DataSize(DataSize),
        .Signed(Signed), .Addr(Addr), .DataIn(DataIn),
        .DataOut(dout0), .MOC(moc0), .Busy(busy0), .AlignErr(aerr0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, measure MOC latency, optionally hold MFA, then release.
    task automatic run_op(input logic sel, input logic rw, input logic [1:0] sz,
                          input logic sg, input logic [8:0] a, input logic [31:0] d,
                          input int hold, input int exp_lat, input logic exp_err,
                          input string tag);
        int lat;
        @(negedge Clk);
        RW = rw; DataSize = sz; Signed = sg; Addr = a; DataIn = d;
        if (sel) MFA0 = 1'b1; else MFA = 1'b1;
        @(posedge Clk);
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (i == 0) check({tag, "_busy"}, 32'(sel ? busy0 : busy), 32'd1);
            if (sel ? moc0 : moc) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_aerr"}, 32'(sel ? aerr0 : aerr), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            check({tag, "_hold_moc"}, 32'(sel ? moc0 : moc), 32'd1);
            check({tag, "_hold_busy"}, 32'(sel ? busy0 : busy), 32'd1);
        end
        MFA = 1'b0; MFA0 = 1'b0;
        @(negedge Clk);
        check({tag, "_rel_moc"}, 32'(sel ? moc0 : moc), 32'd0);
        check({tag, "_rel_busy"}, 32'(sel ? busy0 : busy), 32'd0);
        check({tag, "_rel_aerr"}, 32'(sel ? aerr0 : aerr), 32'd0);
    endtask

    initial begin
        Clear = 1'b0; MFA = 1'b0; MFA0 = 1'b0; RW = 1'b1; DataSize = 2'b10;
        Signed = 1'b0; Addr = '0; DataIn = '0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        check("rst_moc", 32'(moc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_aerr", 32'(aerr), 32'd0);
        check("rst_dout", dout, 32'd0);
        check("rst_dout0", dout0, 32'd0);
        Clear = 1'b1;

        // word write then read back at address 0
        run_op(0, 0, 2'b10, 0, 9'd0, 32'h12345678, 0, 3, 0, "wr_w0");
        check("mem0", 32'(dut.Mem[0]), 32'h12);
        check("mem3", 32'(dut.Mem[3]), 32'h78);
        run_op(0, 1, 2'b10, 0, 9'd0, 32'h0, 0, 3, 0, "rd_w0");
        check("rd_w0_dat", dout, 32'h12345678);

        // byte reads with and without sign extension
        run_op(0, 0, 2'b00, 0, 9'd2, 32'h000000F0, 0, 3, 0, "wr_b2");
        run_op(0, 1, 2'b00, 1, 9'd2, 32'h0, 0, 3, 0, "rd_b2s");
        check("rd_b2s_dat", dout, 32'hFFFFFFF0);
        run_op(0, 1, 2'b00, 0, 9'd2, 32'h0, 0, 3, 0, "rd_b2u");
        check("rd_b2u_dat", dout, 32'h000000F0);

        // halfword reads
        run_op(0, 1, 2'b01, 1, 9'd2, 32'h0, 0, 3, 0, "rd_h2s");
        check("rd_h2s_dat", dout, 32'hFFFFF078);
        run_op(0, 1, 2'b01, 0, 9'd0, 32'h0, 0, 3, 0, "rd_h0u");
        check("rd_h0u_dat", dout, 32'h00001234);

        // half write lands in the high half of a word
        run_op(0, 0, 2'b10, 0, 9'd4, 32'h00000000, 0, 3, 0, "wr_w4");
        run_op(0, 0, 2'b01, 0, 9'd4, 32'hDEADBEEF, 0, 3, 0, "wr_h4");
        run_op(0, 1, 2'b10, 0, 9'd4, 32'h0, 0, 3, 0, "rd_w4");
        check("rd_w4_dat", dout, 32'hBEEF0000);

        // misaligned word write is rejected and leaves memory alone
        run_op(0, 0, 2'b10, 0, 9'd8, 32'h11223344, 0, 3, 0, "wr_w8");
        run_op(0, 0, 2'b10, 0, 9'd6, 32'hAABBCCDD, 0, 3, 1, "wr_w6");
        check("w6_mem6", 32'(dut.Mem[6]), 32'h00);
        check("w6_mem7", 32'(dut.Mem[7]), 32'h00);
        check("w6_mem8", 32'(dut.Mem[8]), 32'h11);
        check("w6_mem9", 32'(dut.Mem[9]), 32'h22);
        check("w6_dout", dout, 32'hBEEF0000);

        // top-of-array boundaries
        run_op(0, 1, 2'b10, 0, 9'd510, 32'h0, 0, 3, 1, "rd_w510");
        check("w510_dout", dout, 32'hBEEF0000);
        run_op(0, 0, 2'b00, 0, 9'd511, 32'h0000005A, 0, 3, 0, "wr_b511");
        run_op(0, 1, 2'b00, 0, 9'd511, 32'h0, 0, 3, 0, "rd_b511");
        check("rd_b511_dat", dout, 32'h0000005A);
        run_op(0, 1, 2'b01, 0, 9'd511, 32'h0, 0, 3, 1, "rd_h511");
        run_op(0, 1, 2'b11, 0, 9'd0, 32'h0, 0, 3, 1, "rd_sz3");
        run_op(0, 1, 2'b01, 0, 9'd1, 32'h0, 0, 3, 1, "rd_h1");
        check("err_dout", dout, 32'h0000005A);

        // hold MFA after MOC: op completes once and stays in DONE
        run_op(0, 0, 2'b00, 0, 9'd12, 32'h00000001, 5, 3, 0, "hold");
        check("hold_mem12", 32'(dut.Mem[12]), 32'h01);

        // zero wait states
        run_op(1, 0, 2'b10, 0, 9'd0, 32'hCAFEF00D, 0, 1, 0, "z_wr");
        run_op(1, 1, 2'b10, 0, 9'd0, 32'h0, 3, 1, 0, "z_rd");
        check("z_rd_dat", dout0, 32'hCAFEF00D);

        // reset during WAIT drops the write
        @(negedge Clk);
        RW = 1'b0; DataSize = 2'b10; Addr = 9'd8; DataIn = 32'h55667788; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Clear = 1'b0; MFA = 1'b0;
        @(negedge Clk);
        check("rw_moc", 32'(moc), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_aerr", 32'(aerr), 32'd0);
        check("rw_dout", dout, 32'd0);
        Clear = 1'b1;
        repeat (4) @(negedge Clk);
        check("rw_mem8", 32'(dut.Mem[8]), 32'h11);
        check("rw_mem11", 32'(dut.Mem[11]), 32'h44);
        run_op(0, 1, 2'b10, 0, 9'd8, 32'h0, 0, 3, 0, "post_rst");
        check("post_rst_dat", dout, 32'h11223344);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
